// File: rtl/image_spike_encoder.sv
// Rate-style spike encoder: latches an image on a NEW_IMAGE rise and streams per-timestep pixel spikes plus timestep markers.
// Optional build macro SPIKE_ENC_LFSR_EN swaps the ramped threshold for an 8-bit LFSR threshold.
module image_spike_encoder #(
    parameter int         IMAGE_SIZE      = 256,
    parameter int         IMAGE_SIZE_BITS = 8,
    parameter int         PIXEL_BITS      = 8,
    parameter int         N_STEPS         = 16,
    parameter int         THRESH_STEP     = 16,
    parameter logic [7:0] LFSR_SEED       = 8'hA5
) (
    input  logic                                  CLK,
    input  logic                                  RST,
    input  logic [IMAGE_SIZE-1:0][PIXEL_BITS-1:0] IMAGE,
    input  logic                                  NEW_IMAGE,
    output logic                                  EVT_VALID,
    input  logic                                  EVT_READY,
    output logic [IMAGE_SIZE_BITS-1:0]            EVT_ADDR,
    output logic                                  EVT_TSTEP,
    output logic                                  BUSY,
    output logic                                  DONE
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SCAN  = 2'd1;
    localparam logic [1:0] EMIT  = 2'd2;
    localparam logic [1:0] TSEND = 2'd3;

    localparam int TS_W = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
    localparam logic [IMAGE_SIZE_BITS-1:0] LAST_IDX = IMAGE_SIZE_BITS'(IMAGE_SIZE - 1);
    localparam logic [TS_W-1:0]            LAST_TS  = TS_W'(N_STEPS - 1);

    // Elaboration-time sanity on the configuration.
    if (N_STEPS < 1 || N_STEPS > 256 || LFSR_SEED == 8'h00 || THRESH_STEP < 0 ||
        IMAGE_SIZE < 1 || IMAGE_SIZE > (1 << IMAGE_SIZE_BITS)) begin : g_bad_param
        $error("image_spike_encoder: illegal parameter combination");
    end

    logic [1:0]                            state;
    logic                                  new_q;
    logic                                  rise;
    logic [IMAGE_SIZE-1:0][PIXEL_BITS-1:0] img_buf;
    logic [IMAGE_SIZE_BITS-1:0]            idx;
    logic [TS_W-1:0]                       tstep;
    logic [PIXEL_BITS-1:0]                 pix;
    logic                                  spike;
    logic                                  last_pix;
    logic                                  xfer;
    logic                                  start;

    assign rise     = NEW_IMAGE & ~new_q;
    assign start    = (state == IDLE) && rise;
    assign pix      = img_buf[idx];
    assign last_pix = (idx == LAST_IDX);
    assign xfer     = EVT_VALID & EVT_READY;

`ifdef SPIKE_ENC_LFSR_EN
    localparam int CMP_W = (PIXEL_BITS > 8) ? PIXEL_BITS : 8;

    logic [7:0] lfsr;

    // Fibonacci LFSR, taps 8,6,5,4; advances once for every pixel evaluated.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            lfsr <= LFSR_SEED;
        else if (start)
            lfsr <= LFSR_SEED;
        else if (state == SCAN)
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign spike = CMP_W'(pix) > CMP_W'(lfsr);
`else
    logic [PIXEL_BITS-1:0] thr;

    // Threshold ramps once per completed timestep and wraps naturally.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            thr <= '0;
        else if (start)
            thr <= '0;
        else if (state == TSEND && xfer && tstep != LAST_TS)
            thr <= thr + PIXEL_BITS'(THRESH_STEP);
    end

    assign spike = pix > thr;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            new_q     <= 1'b0;
            img_buf   <= '0;
            idx       <= '0;
            tstep     <= '0;
            EVT_VALID <= 1'b0;
            EVT_ADDR  <= '0;
            EVT_TSTEP <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            new_q <= NEW_IMAGE;
            DONE  <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        img_buf <= IMAGE;
                        idx     <= '0;
                        tstep   <= '0;
                        BUSY    <= 1'b1;
                        state   <= SCAN;
                    end
                end
                SCAN: begin
                    if (spike) begin
                        EVT_VALID <= 1'b1;
                        EVT_ADDR  <= idx;
                        EVT_TSTEP <= 1'b0;
                        state     <= EMIT;
                    end else if (last_pix) begin
                        EVT_VALID <= 1'b1;
                        EVT_ADDR  <= '0;
                        EVT_TSTEP <= 1'b1;
                        state     <= TSEND;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                EMIT: begin
                    // A spike on the last pixel hands straight over to the marker.
                    if (xfer) begin
                        if (last_pix) begin
                            EVT_ADDR  <= '0;
                            EVT_TSTEP <= 1'b1;
                            state     <= TSEND;
                        end else begin
                            EVT_VALID <= 1'b0;
                            idx       <= idx + 1'b1;
                            state     <= SCAN;
                        end
                    end
                end
                TSEND: begin
                    if (xfer) begin
                        EVT_VALID <= 1'b0;
                        EVT_TSTEP <= 1'b0;
                        if (tstep == LAST_TS) begin
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            tstep <= tstep + 1'b1;
                            idx   <= '0;
                            state <= SCAN;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_image_spike_encoder.sv
// Scoreboard bench for image_spike_encoder: expected event streams come from a timestep-by-timestep reference model.
module tb_image_spike_encoder;
    localparam int IMG_N = 256;
    localparam int NS    = 4;
    localparam int TS    = 64;

    typedef logic [IMG_N-1:0][7:0] img_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    img_t       IMAGE = '0;
    logic       NEW_IMAGE = 1'b0;
    logic       EVT_READY = 1'b1;
    logic       EVT_VALID, EVT_TSTEP, BUSY, DONE;
    logic [7:0] EVT_ADDR;

    img_t       img2 = '0;
    logic       new2 = 1'b0;
    logic       ready2 = 1'b1;
    logic       valid2, tstep2, busy2, done2;
    logic [7:0] addr2;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int busy_cyc = 0;
    int done2_cnt = 0;
    int mark2 = 0;
    int spike2 = 0;
    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];

    always #5 CLK = ~CLK;

    image_spike_encoder #(.N_STEPS(NS), .THRESH_STEP(TS)) u_dut (
        .CLK(CLK), .RST(RST), .IMAGE(IMAGE), .NEW_IMAGE(NEW_IMAGE),
        .EVT_VALID(EVT_VALID), .EVT_READY(EVT_READY), .EVT_ADDR(EVT_ADDR),
        .EVT_TSTEP(EVT_TSTEP), .BUSY(BUSY), .DONE(DONE)
    );

    image_spike_encoder u_dut16 (
        .CLK(CLK), .RST(RST), .IMAGE(img2), .NEW_IMAGE(new2),
        .EVT_VALID(valid2), .EVT_READY(ready2), .EVT_ADDR(addr2),
        .EVT_TSTEP(tstep2), .BUSY(busy2), .DONE(done2)
    );

    // Transfers are sampled mid-cycle; inputs only change just after the rising edge.
    always @(negedge CLK) begin
        if (!RST) begin
            if (EVT_VALID && EVT_READY) got_q.push_back({EVT_TSTEP, EVT_ADDR});
            if (DONE) done_cnt++;
            if (BUSY) busy_cyc++;
            if (valid2 && ready2) begin
                if (tstep2) mark2++;
                else spike2++;
            end
            if (done2) done2_cnt++;
        end
    end

    task automatic model_push(input img_t img);
        logic [7:0] thr;
`ifdef SPIKE_ENC_LFSR_EN
        thr = 8'hA5;
`else
        thr = 8'h00;
`endif
        for (int t = 0; t < NS; t++) begin
            for (int i = 0; i < IMG_N; i++) begin
                if (img[i] > thr) exp_q.push_back({1'b0, 8'(i)});
`ifdef SPIKE_ENC_LFSR_EN
                thr = {thr[6:0], thr[7] ^ thr[5] ^ thr[4] ^ thr[3]};
`endif
            end
            exp_q.push_back({1'b1, 8'h00});
`ifndef SPIKE_ENC_LFSR_EN
            thr = thr + 8'(TS);
`endif
        end
    endtask

    task automatic start_image(input img_t img);
        model_push(img);
        @(posedge CLK); #1;
        IMAGE = img;
        NEW_IMAGE = 1'b1;
        @(posedge CLK); #1;
        NEW_IMAGE = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input bit rnd, output bit to);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(posedge CLK); #1;
            n++;
            if (rnd) EVT_READY = ($urandom_range(0, 3) != 0);
        end
        EVT_READY = 1'b1;
        to = (done_cnt < target);
    endtask

    function automatic img_t rand_img(input int density);
        img_t r;
        r = '0;
        for (int i = 0; i < IMG_N; i++)
            if ($urandom_range(0, 99) < density) r[i] = 8'($urandom_range(1, 255));
        return r;
    endfunction

    task automatic test_reset;
        #2 RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        checks++; if (EVT_VALID !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", EVT_VALID); end
        checks++; if (EVT_ADDR !== 8'h00) begin failures++; $display("FAIL rst_addr got=%h exp=00", EVT_ADDR); end
        checks++; if (EVT_TSTEP !== 1'b0) begin failures++; $display("FAIL rst_tstep got=%b exp=0", EVT_TSTEP); end
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", BUSY); end
        checks++; if (DONE !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", DONE); end
        RST = 1'b0;
    endtask

    task automatic test_basic;
        img_t img;
        int d0, n_exp;
        bit to;
        logic [8:0] e, g;
        img = '0;
        img[10] = 8'd200;
        img[20] = 8'd100;
        exp_q.delete(); got_q.delete();
        d0 = done_cnt;
        busy_cyc = 0;
        start_image(img);
        n_exp = exp_q.size();
        wait_done(d0 + 1, 5000, 1'b0, to);
        repeat (5) @(posedge CLK);
        #1;
        checks++; if (to) begin failures++; $display("FAIL basic_timeout done=%0d exp=%0d", done_cnt - d0, 1); end
        checks++; if (got_q.size() != n_exp) begin failures++; $display("FAIL basic_count got=%0d exp=%0d", got_q.size(), n_exp); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++; if (g !== e) begin failures++; $display("FAIL basic_event got=%h exp=%h", g, e); end
        end
        checks++; if (busy_cyc != IMG_N * NS + n_exp) begin failures++; $display("FAIL basic_cycles got=%0d exp=%0d", busy_cyc, IMG_N * NS + n_exp); end
        checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL basic_done got=%0d exp=1", done_cnt - d0); end
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL basic_busy_after got=%b exp=0", BUSY); end
    endtask

    task automatic test_stall;
        img_t img;
        int d0, n;
        bit to;
        logic [7:0] a0;
        logic [8:0] e, g;
        img = '0;
        img[3] = 8'd255;
        img[7] = 8'd255;
        exp_q.delete(); got_q.delete();
        d0 = done_cnt;
        EVT_READY = 1'b0;
        start_image(img);
        n = 0;
        while (!(EVT_VALID === 1'b1 && EVT_TSTEP === 1'b0) && n < 600) begin
            @(posedge CLK); #1;
            n++;
        end
        a0 = EVT_ADDR;
        checks++; if (a0 !== 8'd3) begin failures++; $display("FAIL stall_first_addr got=%0d exp=3", a0); end
        for (int c = 0; c < 10; c++) begin
            @(posedge CLK); #1;
            checks++;
            if (EVT_VALID !== 1'b1 || EVT_ADDR !== a0 || EVT_TSTEP !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold cyc=%0d got=%b/%0d/%b exp=1/%0d/0", c, EVT_VALID, EVT_ADDR, EVT_TSTEP, a0);
            end
        end
        EVT_READY = 1'b1;
        wait_done(d0 + 1, 5000, 1'b0, to);
        checks++; if (to) begin failures++; $display("FAIL stall_timeout done=%0d exp=1", done_cnt - d0); end
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL stall_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++; if (g !== e) begin failures++; $display("FAIL stall_event got=%h exp=%h", g, e); end
        end
    endtask

    task automatic test_ignore;
        img_t img;
        int d0;
        bit to;
        logic [8:0] e, g;
        img = rand_img(20);
        exp_q.delete(); got_q.delete();
        d0 = done_cnt;
        start_image(img);
        repeat (40) @(posedge CLK);
        #1;
        IMAGE = ~img;
        NEW_IMAGE = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        NEW_IMAGE = 1'b0;
        IMAGE = rand_img(90);
        wait_done(d0 + 1, 5000, 1'b0, to);
        repeat (10) @(posedge CLK);
        #1;
        checks++; if (to) begin failures++; $display("FAIL ignore_timeout done=%0d exp=1", done_cnt - d0); end
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL ignore_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++; if (g !== e) begin failures++; $display("FAIL ignore_event got=%h exp=%h", g, e); end
        end
        checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL ignore_done got=%0d exp=1", done_cnt - d0); end
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL ignore_busy_after got=%b exp=0", BUSY); end
    endtask

    task automatic test_reset_mid;
        img_t img;
        int d0;
        bit to;
        logic [8:0] e, g;
        img = '0;
        img[2] = 8'd90;
        img[5] = 8'd250;
        start_image(img);
        repeat (20) @(posedge CLK);
        #1;
        RST = 1'b1;
        #1;
        checks++; if (EVT_VALID !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", EVT_VALID); end
        checks++; if (EVT_ADDR !== 8'h00) begin failures++; $display("FAIL rmid_addr got=%h exp=00", EVT_ADDR); end
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", BUSY); end
        checks++; if (EVT_TSTEP !== 1'b0 || DONE !== 1'b0) begin failures++; $display("FAIL rmid_tstep_done got=%b%b exp=00", EVT_TSTEP, DONE); end
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        exp_q.delete(); got_q.delete();
        repeat (30) @(posedge CLK);
        #1;
        checks++; if (got_q.size() != 0) begin failures++; $display("FAIL rmid_no_events got=%0d exp=0", got_q.size()); end
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL rmid_idle got=%b exp=0", BUSY); end
        d0 = done_cnt;
        img[0] = 8'd255;
        start_image(img);
        wait_done(d0 + 1, 5000, 1'b0, to);
        checks++; if (to) begin failures++; $display("FAIL rmid_timeout done=%0d exp=1", done_cnt - d0); end
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rmid_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++; if (g !== e) begin failures++; $display("FAIL rmid_event got=%h exp=%h", g, e); end
        end
    endtask

    task automatic test_back_to_back;
        img_t img;
        int d0, zhits;
        bit to;
        logic [8:0] e, g;
        for (int k = 0; k < 2; k++) begin
            img = rand_img(60);
            exp_q.delete(); got_q.delete();
            d0 = done_cnt;
            start_image(img);
            wait_done(d0 + 1, 8000, 1'b1, to);
            checks++; if (to) begin failures++; $display("FAIL b2b_timeout img=%0d done=%0d exp=1", k, done_cnt - d0); end
            checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL b2b_count img=%0d got=%0d exp=%0d", k, got_q.size(), exp_q.size()); end
            zhits = 0;
            foreach (got_q[i]) if (!got_q[i][8] && img[got_q[i][7:0]] == 8'd0) zhits++;
            checks++; if (zhits != 0) begin failures++; $display("FAIL b2b_zero_pixel img=%0d got=%0d exp=0", k, zhits); end
            while (exp_q.size() > 0 && got_q.size() > 0) begin
                e = exp_q.pop_front(); g = got_q.pop_front();
                checks++; if (g !== e) begin failures++; $display("FAIL b2b_event img=%0d got=%h exp=%h", k, g, e); end
            end
        end
    endtask

    task automatic test_zero16;
        int n;
        @(posedge CLK); #1;
        new2 = 1'b1;
        @(posedge CLK); #1;
        new2 = 1'b0;
        n = 0;
        while (done2_cnt < 1 && n < 6000) begin
            @(posedge CLK); #1;
            n++;
        end
        repeat (5) @(posedge CLK);
        #1;
        checks++; if (mark2 != 16) begin failures++; $display("FAIL zero16_markers got=%0d exp=16", mark2); end
        checks++; if (spike2 != 0) begin failures++; $display("FAIL zero16_spikes got=%0d exp=0", spike2); end
        checks++; if (done2_cnt != 1) begin failures++; $display("FAIL zero16_done got=%0d exp=1", done2_cnt); end
        checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL zero16_busy got=%b exp=0", busy2); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_stall;
        test_ignore;
        test_reset_mid;
        test_back_to_back;
        test_zero16;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/image_spike_encoder.md
IMAGE_SPIKE_ENCODER -- requirements
Module: image_spike_encoder

Interface
REQ-001 SHALL have parameter IMAGE_SIZE, default 256, number of pixels and input neurons.
REQ-002 SHALL have parameter IMAGE_SIZE_BITS, default 8, pixel/neuron address width.
REQ-003 SHALL have parameter PIXEL_BITS, default 8, pixel width, unsigned.
REQ-004 SHALL have parameter N_STEPS, default 16, timesteps per image, range 1..256.
REQ-005 SHALL have parameter THRESH_STEP, default 16, per-timestep threshold increment for deterministic mode.
REQ-006 SHALL have parameter LFSR_SEED, default 8'hA5, nonzero LFSR seed.
REQ-007 SHALL have port CLK, input, 1, single clock; all logic on its rising edge.
REQ-008 SHALL have port RST, input, 1, reset, asynchronous and active-high.
REQ-009 SHALL have port IMAGE, input, IMAGE_SIZE x PIXEL_BITS, pixel array from the AXI slave.
REQ-010 SHALL have port NEW_IMAGE, input, 1, level from the AXI slave; a rising edge requests encoding.
REQ-011 SHALL have port EVT_VALID, output, 1, event valid.
REQ-012 SHALL have port EVT_READY, input, 1, SNN core accepts event.
REQ-013 SHALL have port EVT_ADDR, output, IMAGE_SIZE_BITS, spiking neuron address.
REQ-014 SHALL have port EVT_TSTEP, output, 1, marks an end-of-timestep event (EVT_ADDR=0).
REQ-015 SHALL have port BUSY, output, 1, high outside IDLE.
REQ-016 SHALL have port DONE, output, 1, one-cycle pulse when the last timestep marker is accepted.

Function
REQ-017 SHALL register NEW_IMAGE once (new_q); rise = NEW_IMAGE & ~new_q.
REQ-018 SHALL implement FSM IDLE, SCAN, EMIT, TSEND; all outputs registered.
REQ-019 In IDLE on rise: SHALL copy IMAGE into an internal buffer on that edge, clear pixel index and timestep, load threshold source, go SCAN.
REQ-020 SCAN: SHALL evaluate buffer[idx] in one cycle; spike iff buffer[idx] > thr (strict, unsigned).
REQ-021 On spike: SHALL enter EMIT with EVT_VALID=1, EVT_ADDR=idx, EVT_TSTEP=0.
REQ-022 On no spike: SHALL advance idx; after idx=IMAGE_SIZE-1 SHALL go TSEND, else stay in SCAN.
REQ-023 EMIT/TSEND: SHALL hold EVT_VALID, EVT_ADDR, EVT_TSTEP stable until EVT_VALID&EVT_READY; EVT_VALID drops the cycle after transfer.
REQ-024 After EMIT transfer: SHALL advance idx as in REQ-022.
REQ-025 TSEND: SHALL present EVT_TSTEP=1, EVT_ADDR=0; on transfer, if timestep=N_STEPS-1, pulse DONE and go IDLE, else increment timestep, update threshold, clear idx, go SCAN.
REQ-026 Timing: with EVT_READY=1, a non-spiking pixel costs 1 cycle, a spiking pixel 2 cycles, a marker 1 cycle.
REQ-027 SHALL ignore rise outside IDLE; SHALL ignore IMAGE changes after the latch.
REQ-028 Deterministic threshold: thr=0 at timestep 0, thr += THRESH_STEP (mod 2^PIXEL_BITS) per timestep; pixel 0 never spikes.

Reset
REQ-029 On RST: SHALL force IDLE, EVT_VALID=0, EVT_ADDR=0, EVT_TSTEP=0, BUSY=0, DONE=0, new_q=0, idx=0, timestep=0, thr=0, LFSR=LFSR_SEED, buffer=0.
REQ-030 RST mid-operation SHALL abort without emitting further events; encoding restarts only on a new rise.

Configuration
REQ-031 With SPIKE_ENC_LFSR_EN defined: thr SHALL be an 8-bit Fibonacci LFSR (taps 8,6,5,4), seeded LFSR_SEED on each accepted rise, stepped once per SCAN evaluation; REQ-028 does not apply.
REQ-032 Without SPIKE_ENC_LFSR_EN: SHALL use the deterministic threshold of REQ-028 and SHALL contain no LFSR logic.

Verification
REQ-033 Without macro, N_STEPS=4, THRESH_STEP=64, pixel10=200, pixel20=100, others 0 -> ts0,1 events {10,20,marker}; ts2,3 {10,marker}; one DONE.
REQ-034 EVT_READY low 10 cycles during EMIT -> EVT_VALID/EVT_ADDR stable; no event lost or duplicated.
REQ-035 All-zero image, N_STEPS=16 -> exactly 16 marker events, no spikes, DONE once, BUSY low after.
REQ-036 Second NEW_IMAGE rise and IMAGE changed during SCAN -> event stream identical to undisturbed run.
REQ-037 RST asserted mid-SCAN -> all outputs at reset values immediately; next rise restarts at idx 0, ts 0.
REQ-038 With macro, random image -> event stream matches reference model seeded 8'hA5; pixel-0 addresses never emitted.
